// File: rtl/unsort3.sv
// unsort3: restores original operand order a,b,c from a sorted triple plus its sequence code,
//    with valid/ready on both sides, a 2-entry output FIFO and error flagging/counting.
// Ports:
//    clk, rst             clock (rising edge), asynchronous active-high reset
//    in_valid / in_ready  input handshake; in_ready means the FIFO is not full
//    no1, no2, no3, seq   sorted triple (largest first) and its 3-bit sequence code
//    out_valid/out_ready  output handshake for the FIFO head
//    a, b, c, err         head entry; when empty, the last popped entry (0 after reset)
//    err_cnt              saturating count of accepted erroneous entries
module unsort3 #(
   parameter int width = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] no1,
   input  logic [width-1:0] no2,
   input  logic [width-1:0] no3,
   input  logic [2:0]       seq,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] a,
   output logic [width-1:0] b,
   output logic [width-1:0] c,
   output logic             err,
   output logic [7:0]       err_cnt
);
   localparam int EW = 3 * width + 1;

   logic [EW-1:0]    r_mem [2];
   logic [EW-1:0]    r_last;
   logic             r_wp, r_rp;
   logic [1:0]       r_cnt;
   logic [7:0]       r_err_cnt;
   logic [width-1:0] w_a, w_b, w_c;
   logic             w_ill, w_bad, w_push, w_pop;
   logic [EW-1:0]    w_ent, w_head;

   // Codes 10x are illegal; the case default zeroes them out.
   always_comb begin
      w_ill = seq[2:1] == 2'b10;
      w_bad = !(no1 >= no2 && no2 >= no3);
      {w_a, w_b, w_c} = '0;
      case (seq)
         3'b000:  {w_a, w_b, w_c} = {no1, no2, no3};
         3'b001:  {w_a, w_b, w_c} = {no1, no3, no2};
         3'b011:  {w_a, w_b, w_c} = {no2, no1, no3};
         3'b010:  {w_a, w_b, w_c} = {no3, no1, no2};
         3'b110:  {w_a, w_b, w_c} = {no2, no3, no1};
         3'b111:  {w_a, w_b, w_c} = {no3, no2, no1};
         default: {w_a, w_b, w_c} = '0;
      endcase
   end

   assign w_ent     = {w_a, w_b, w_c, w_ill | w_bad};
   assign in_ready  = r_cnt != 2'd2;
   assign out_valid = r_cnt != 2'd0;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_head    = out_valid ? r_mem[r_rp] : r_last;
   assign {a, b, c, err} = w_head;
   assign err_cnt   = r_err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0]  <= '0;
         r_mem[1]  <= '0;
         r_last    <= '0;
         r_wp      <= 1'b0;
         r_rp      <= 1'b0;
         r_cnt     <= 2'd0;
         r_err_cnt <= 8'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= w_ent;
            r_wp        <= ~r_wp;
         end
         if (w_pop) begin
            r_last <= r_mem[r_rp];
            r_rp   <= ~r_rp;
         end
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
         if (w_push && w_ent[0] && r_err_cnt != 8'hff)
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end
endmodule
